// File: rtl/i2c_pkg.sv
// Shared constants and FSM state types for the I2C FIFO scheduler.
package i2c_pkg;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int WORD_W = ADDR_W + DATA_W;
    localparam int CNT_W  = $clog2(WORD_W);

    typedef enum logic {
        W_IDLE,
        W_SHIFT
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_SHIFT,
        R_WAIT
    } rstate_t;
endpackage

// File: rtl/i2c_rr_arb2.sv
// Two-way round-robin arbiter: the requester granted last loses the next tie.
module i2c_rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_advance,
    output logic o_pick1
);
    // Set when requester 1 holds priority; reset favours requester 0.
    logic r_ptr;

    assign o_pick1 = i_req1 & (~i_req0 | r_ptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (i_advance) begin
            r_ptr <= ~o_pick1;
        end
    end
endmodule

// File: rtl/i2c_fifo_sched.sv
// Shares the serial I2C transmit FIFO between two requesters: serializes granted
// words into the FIFO, tracks committed words and paces read-out to the master.
module i2c_fifo_sched
    import i2c_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req0,
    input  logic                       req1,
    input  logic [ADDR_W-1:0]          addr0,
    input  logic [ADDR_W-1:0]          addr1,
    input  logic [DATA_W-1:0]          data0,
    input  logic [DATA_W-1:0]          data1,
    output logic                       gnt0,
    output logic                       gnt1,
    output logic                       fifo_wr_en,
    output logic                       fifo_din,
    output logic                       fifo_rd_en,
    input  logic                       m_ready,
    output logic                       m_start,
    input  logic                       m_done,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       busy
);
    localparam int                 LVL_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(WORD_W - 1);
    localparam logic [LVL_W-1:0]   FULL_LVL = LVL_W'(DEPTH);

    wstate_t             r_wstate;
    rstate_t             r_rstate;
    logic [WORD_W-1:0]   r_shreg;
    logic [CNT_W-1:0]    r_wcnt;
    logic [CNT_W-1:0]    r_rcnt;
    logic [LVL_W-1:0]    r_level;
    logic                r_gnt0;
    logic                r_gnt1;
    logic                r_wr_en;
    logic                r_rd_en;
    logic                r_m_start;

    logic                w_grant;
    logic                w_pick1;
    logic                w_wr_done;
    logic                w_rd_done;

    // Only committed words count, so an idle writer with room may always start.
    assign w_grant   = (r_wstate == W_IDLE) && (req0 || req1) && (r_level < FULL_LVL);
    assign w_wr_done = (r_wstate == W_SHIFT) && (r_wcnt == LAST_BIT);
    assign w_rd_done = (r_rstate == R_SHIFT) && (r_rcnt == LAST_BIT);

    i2c_rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst),
        .i_req0    (req0),
        .i_req1    (req1),
        .i_advance (w_grant),
        .o_pick1   (w_pick1)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wstate <= W_IDLE;
            r_shreg  <= '0;
            r_wcnt   <= '0;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_wr_en  <= 1'b0;
        end else begin
            r_gnt0 <= 1'b0;
            r_gnt1 <= 1'b0;
            case (r_wstate)
                W_IDLE: begin
                    if (w_grant) begin
                        r_wstate <= W_SHIFT;
                        r_wr_en  <= 1'b1;
                        r_wcnt   <= '0;
                        r_gnt0   <= ~w_pick1;
                        r_gnt1   <= w_pick1;
                        r_shreg  <= w_pick1 ? {addr1, data1} : {addr0, data0};
                    end
                end
                W_SHIFT: begin
                    // Clearing on the last bit keeps fifo_din low between words.
                    if (r_wcnt == LAST_BIT) begin
                        r_wstate <= W_IDLE;
                        r_wr_en  <= 1'b0;
                        r_shreg  <= '0;
                    end else begin
                        r_wcnt  <= r_wcnt + 1'b1;
                        r_shreg <= {r_shreg[WORD_W-2:0], 1'b0};
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rstate  <= R_IDLE;
            r_rcnt    <= '0;
            r_rd_en   <= 1'b0;
            r_m_start <= 1'b0;
        end else begin
            r_m_start <= 1'b0;
            case (r_rstate)
                R_IDLE: begin
                    if ((r_level != '0) && m_ready) begin
                        r_rstate  <= R_SHIFT;
                        r_rcnt    <= '0;
                        r_rd_en   <= 1'b1;
                        r_m_start <= 1'b1;
                    end
                end
                R_SHIFT: begin
                    if (r_rcnt == LAST_BIT) begin
                        r_rstate <= R_WAIT;
                        r_rd_en  <= 1'b0;
                    end else begin
                        r_rcnt <= r_rcnt + 1'b1;
                    end
                end
                R_WAIT: begin
                    if (m_done) begin
                        r_rstate <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_level <= '0;
        end else begin
            case ({w_wr_done, w_rd_done})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign gnt0       = r_gnt0;
    assign gnt1       = r_gnt1;
    assign fifo_wr_en = r_wr_en;
    assign fifo_din   = r_shreg[WORD_W-1];
    assign fifo_rd_en = r_rd_en;
    assign m_start    = r_m_start;
    assign level      = r_level;
    assign busy       = (r_wstate != W_IDLE) || (r_rstate != R_IDLE);
endmodule

// File: doc/i2c_fifo_sched.md
# i2c_fifo_sched

Controller that shares the serial I2C transmit FIFO between two requesters and drains it to the I2C master. It arbitrates round-robin between requesters, serializes each 7-bit address + 8-bit data word MSB-first onto the FIFO's 1-bit write port, and tracks word occupancy. When the master is ready, it sequences FIFO read-out one word at a time and waits for the master's completion handshake. It sits between the host-side request logic and the `i2c_fifo`/I2C master pair.

## Interface
- `ADDR_W`, 7, I2C address width
- `DATA_W`, 8, payload width; word width `WORD_W = ADDR_W + DATA_W` (15)
- `DEPTH`, 8, FIFO capacity in words
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `req0` / `req1` in 1: requester wants to enqueue a word; held until granted
- `addr0` / `addr1` in `ADDR_W`: requester address, sampled on grant
- `data0` / `data1` in `DATA_W`: requester payload, sampled on grant
- `gnt0` / `gnt1` out 1: one-cycle grant pulse
- `fifo_wr_en` out 1: FIFO write strobe, high one cycle per serialized bit
- `fifo_din` out 1: serial bit to FIFO `addr_data`
- `fifo_rd_en` out 1: FIFO read strobe, high one cycle per bit read
- `m_ready` in 1: master idle, can accept a word
- `m_start` out 1: one-cycle pulse on the first read cycle of a word
- `m_done` in 1: master finished transmitting the current word
- `level` out `$clog2(DEPTH+1)`: committed words in FIFO
- `busy` out 1: either FSM not idle

## Operation
- **Write FSM states:** `W_IDLE`, `W_SHIFT`.
  - `W_IDLE` → `W_SHIFT` when (`req0` | `req1`) and `level + 1 <= DEPTH`. The arbiter picks the winner, the matching `gnt` pulses, and `{addr,data}` is latched in a 15-bit shift register.
  - In `W_SHIFT`, `fifo_wr_en` = 1 and `fifo_din` = shreg MSB for exactly `WORD_W` cycles. Bit order: `addr[6]` … `addr[0]`, `data[7]` … `data[0]`. Then return to `W_IDLE`.
- **Arbitration:** 2-way round-robin. The last granted requester gets lowest priority next. After reset, `req0` has priority. A single requester is always granted.
- **Read FSM states:** `R_IDLE`, `R_SHIFT`, `R_WAIT`.
  - `R_IDLE` → `R_SHIFT` when `level > 0` and `m_ready`.
  - `R_SHIFT` holds `fifo_rd_en` = 1 for `WORD_W` cycles; `m_start` is high in the first of these cycles. Then → `R_WAIT`.
  - `R_WAIT` → `R_IDLE` on `m_done`.
- **Level update:**
  - +1 on the edge ending the last `W_SHIFT` cycle.
  - −1 on the edge ending the last `R_SHIFT` cycle.
  - Both on the same edge: unchanged.
  - A word being written is not counted until complete, so it is never read early.
- **Full:** at `level == DEPTH` no grant is issued and requests stay pending. An in-flight write never overflows because the `<= DEPTH` check counts it.
- **Empty:** at `level == 0` the read FSM stays in `R_IDLE` regardless of `m_ready`.
- **`m_done` outside `R_WAIT`:** ignored.
- **Reset (any time, including mid-shift):**
  - All outputs 0, `level` 0, both FSMs idle, arbiter pointer favors `req0`.
  - A partial word is discarded; `i2c_fifo` shares `rst` and clears too.

## Timing
- **Grant:** `gnt` is registered. A request seen in `W_IDLE` at edge N gives `gnt` high in cycle N+1, and that same cycle is the first `W_SHIFT` cycle.
- **Write duration:** 15 cycles with `fifo_wr_en` high. `W_IDLE` lasts at least one cycle between words, so back-to-back words occupy 16 cycles each.
- **Read duration:** 15 cycles with `fifo_rd_en` high, plus the master's `R_WAIT` time.
- **Requester handshake:** the requester drops `req` in the cycle after `gnt`. If `req` is still high after a word completes, it is treated as a new request.

## Structure
- **Shared package `i2c_pkg`:**
  - `ADDR_W`, `DATA_W`, `WORD_W` constants.
  - Write and read FSM state enums.
- **Sub-module `i2c_rr_arb2`:** 2-request round-robin arbiter with a pointer register and an `advance` input.
- **Top level:** the two FSMs, the shift register, the bit counters (`$clog2(WORD_W)` bits each) and the level counter.

## Test plan
- **Single write:** `req0`, `addr0` = 0x0C, `data0` = 0x2A → `gnt0` pulse, then `fifo_din` stream 000110000101010 over 15 `fifo_wr_en` cycles, then `level` = 1.
- **Contention:** `req0` and `req1` held together for 4 words → grants alternate 0,1,0,1, and `level` reaches 4.
- **Full:** `DEPTH` = 8 with `m_ready` = 0 and 9 requests → 8 grants, `level` = 8, and the 9th `req` stays ungranted until one read completes.
- **Drain:** `level` = 2, `m_ready` = 1 → `m_start` and 15 `fifo_rd_en` cycles; `level` = 1 at the end. No second read until `m_done` is pulsed.
- **Simultaneous:** write and read complete on the same edge → `level` unchanged.
- **Reset mid-shift:** `rst` low during bit 7 of a write → all outputs 0 immediately and `level` = 0. After release, `req1` is granted ahead of `req0` only if `req0` is absent.
